// File: rtl/seq_sm_mul.sv
// Sequential sign-magnitude multiplier: magnitudes are multiplied by W-1 shift-add
// steps, sign is resolved up front so a zero result is never negative.
module seq_sm_mul #(
    parameter int unsigned W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-2:0] product
);

    localparam int unsigned MW = W - 1;
    localparam int unsigned PW = 2 * W - 2;
    localparam int unsigned CW = $clog2(W) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [MW-1:0]   mplier;
    logic [CW-1:0]   cnt;
    logic            sign;
    logic            start_sign;

    // Negative-zero operands collapse to zero, so either zero magnitude forces +.
    assign start_sign = (a[W-1] ^ b[W-1]) & (|a[MW-1:0]) & (|b[MW-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        mcand  <= PW'(a[MW-1:0]);
                        mplier <= b[MW-1:0];
                        acc    <= '0;
                        cnt    <= CW'(MW);
                        sign   <= start_sign;
                        busy   <= 1'b1;
                        state  <= StRun;
                    end else begin
                        state <= StIdle;
                    end
                end
                StRun: begin
                    if (cnt != '0) begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - CW'(1);
                    end else begin
                        // All steps retired: publish result on the edge entering DONE.
                        product <= {sign, acc};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= StDone;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sm_mul.sv
// Directed bench for seq_sm_mul: a W=3 and a W=8 instance share clock and reset.
module tb_seq_sm_mul;

    logic        clk;
    logic        rst_n;
    logic        start3, start8;
    logic [2:0]  a3, b3;
    logic [7:0]  a8, b8;
    logic        busy3, done3, busy8, done8;
    logic [4:0]  prod3;
    logic [14:0] prod8;

    int nvec = 0;
    int nerr = 0;

    seq_sm_mul #(.W(3)) u_dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start3),
        .a       (a3),
        .b       (b3),
        .busy    (busy3),
        .done    (done3),
        .product (prod3)
    );

    seq_sm_mul #(.W(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .product (prod8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 3) ? busy3 : busy8;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 3) ? done3 : done8;
    endfunction

    function automatic logic [14:0] get_prod(input int w);
        return (w == 3) ? 15'(prod3) : prod8;
    endfunction

    // Starts one operation (caller is #1 past an edge), scrambles inputs after the
    // start edge, then checks busy, product hold, latency and the final product.
    task automatic op(input int w, input logic [7:0] av, input logic [7:0] bv,
                      input logic [14:0] exp, input string tag);
        logic [14:0] prev;
        int e;
        prev = get_prod(w);
        if (w == 3) begin
            a3 = av[2:0]; b3 = bv[2:0]; start3 = 1'b1;
        end else begin
            a8 = av; b8 = bv; start8 = 1'b1;
        end
        @(posedge clk); #1;
        start3 = 1'b0; start8 = 1'b0;
        a3 = ~a3; b3 = ~b3; a8 = ~a8; b8 = ~b8;
        check({tag, " busy@0"}, 32'(get_busy(w)), 32'd1);
        for (e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (get_done(w)) break;
            check({tag, " hold"}, 32'(get_prod(w)), 32'(prev));
            check({tag, " busy"}, 32'(get_busy(w)), 32'd1);
        end
        check({tag, " latency"}, 32'(e), 32'(w));
        check({tag, " busy@done"}, 32'(get_busy(w)), 32'd0);
        check({tag, " product"}, 32'(get_prod(w)), 32'(exp));
    endtask

    initial begin
        logic [4:0] exp3;
        logic [1:0] am, bm;
        int nd, de;

        rst_n = 1'b0; start3 = 1'b0; start8 = 1'b0;
        a3 = '0; b3 = '0; a8 = '0; b8 = '0;
        #2;
        check("rst busy3", 32'(busy3), 32'd0);
        check("rst done3", 32'(done3), 32'd0);
        check("rst prod3", 32'(prod3), 32'd0);
        check("rst busy8", 32'(busy8), 32'd0);
        check("rst done8", 32'(done8), 32'd0);
        check("rst prod8", 32'(prod8), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // +3 * -3 = -9, started on the first edge after reset release
        op(3, 8'b011, 8'b111, 15'b11001, "p3xm3");
        @(posedge clk); #1;
        check("done one cycle", 32'(done3), 32'd0);
        check("prod held idle", 32'(prod3), 32'b11001);

        // Restart attempt during RUN must be ignored
        a3 = 3'b011; b3 = 3'b011; start3 = 1'b1;
        @(posedge clk); #1;
        a3 = 3'b001; b3 = 3'b001;
        nd = 0; de = 0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            if (e == 1) start3 = 1'b0;
            if (done3) begin
                nd++;
                de = e;
            end
        end
        check("ign start dones", 32'(nd), 32'd1);
        check("ign start edge", 32'(de), 32'd3);
        check("ign start prod", 32'(prod3), 32'b01001);

        op(3, 8'b100, 8'b111, 15'b00000, "negzero");

        // Back-to-back: each op is launched on the DONE cycle of the previous one
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                am = 2'(i & 3);
                bm = 2'(j & 3);
                exp3[3:0] = am * bm;
                exp3[4] = ((i >> 2) != (j >> 2)) && (am != 0) && (bm != 0);
                if (i == 0 && j == 0) begin
                    check("b2b busy", 32'(busy3), 32'd0);
                end
                op(3, 8'(i), 8'(j), 15'(exp3), $sformatf("sweep %0d*%0d", i, j));
                if (done3) begin
                    // Next op starts right now; busy must follow on the next edge
                end
            end
        end
        @(posedge clk); #1;
        check("after sweep idle", 32'(busy3), 32'd0);

        op(8, 8'h85, 8'h83, 15'h000F, "m5xm3");
        op(8, 8'h7F, 8'hFF, 15'h7F01, "max");

        // Abort mid-flight with reset
        a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort busy pre", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy8), 32'd0);
        check("abort done", 32'(done8), 32'd0);
        check("abort prod", 32'(prod8), 32'd0);
        check("abort prod3", 32'(prod3), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nd = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (done8) nd++;
        end
        check("abort no done", 32'(nd), 32'd0);
        check("abort idle", 32'(busy8), 32'd0);

        op(8, 8'h85, 8'h05, 15'h4019, "post abort");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
